// File: rtl/phy_tx_lane_serializer_if.sv
// rtl/phy_tx_lane_serializer_if.sv - lane-set load bus for the PHY TX lane serializer
//
// Purpose: carries one parallel lane set from a producer to the serializer.
// Signals:
//   in_data      NUM_LANES*WIDTH  lane i = in_data[i*WIDTH +: WIDTH]
//   in_valid     NUM_LANES        per-lane valid, bit i belongs to lane i
//   in_load      1                producer offers a set this cycle
//   in_ready     1                serializer accepts the set at the next rising edge
//   skip_invalid 1                compaction mode for the offered set
// Modports: master = producer, slave = serializer.
interface phy_tx_lane_serializer_if #(
  parameter int NUM_LANES = 4,
  parameter int WIDTH     = 8
);
  logic [NUM_LANES*WIDTH-1:0] in_data;
  logic [NUM_LANES-1:0]       in_valid;
  logic                       in_load;
  logic                       in_ready;
  logic                       skip_invalid;

  modport master (
    output in_data,
    output in_valid,
    output in_load,
    output skip_invalid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_load,
    input  skip_invalid,
    output in_ready
  );
endinterface

// File: rtl/phy_tx_lane_serializer.sv
// rtl/phy_tx_lane_serializer.sv - PHY TX lane serializer, NUM_LANES words to one WIDTH stream
//
// Purpose: buffers one lane set and emits it one word per clock in ascending
// lane order, sending IDLE_SYM when nothing is held. In compaction mode only
// valid lanes get a slot. A new set may load on the edge that emits the last
// slot of the current set, so back-to-back sets stream without a gap.
// Ports:
//   clk        rising-edge clock
//   reset_L    asynchronous active-low reset
//   in_if      lane-set load bus (slave side)
//   data_out   serialized word (registered)
//   valid_out  data_out carries a valid lane word (registered)
//   lane_out   source lane of data_out, 0 when idle (registered)
//   busy       a set is held and not fully emitted
module phy_tx_lane_serializer #(
  parameter int               NUM_LANES = 4,
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] IDLE_SYM  = WIDTH'(8'hBC),
  parameter int               LW        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                     clk,
  input  logic                     reset_L,
  phy_tx_lane_serializer_if.slave  in_if,
  output logic [WIDTH-1:0]         data_out,
  output logic                     valid_out,
  output logic [LW-1:0]            lane_out,
  output logic                     busy
);

  logic [WIDTH-1:0]     buf_word [NUM_LANES];
  logic [NUM_LANES-1:0] buf_valid;
  logic                 buf_skip;
  logic                 full;
  logic [LW-1:0]        idx;

  logic [LW-1:0]        hi_idx;     // highest valid lane of the held set
  logic [LW-1:0]        lo_in_idx;  // lowest valid lane of the offered set
  logic [LW-1:0]        nxt_idx;
  logic                 is_last;
  logic                 accept;
  logic                 load_set;

  always_comb begin
    hi_idx    = '0;
    lo_in_idx = '0;
    nxt_idx   = idx + LW'(1);
    for (int i = 0; i < NUM_LANES; i++) begin
      if (buf_valid[i]) hi_idx = LW'(i);
    end
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (in_if.in_valid[i]) lo_in_idx = LW'(i);
    end
    // Compaction: jump straight to the next valid lane above the current one.
    if (buf_skip) begin
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
        if (buf_valid[i] && (i > int'(idx))) nxt_idx = LW'(i);
      end
    end
    is_last = buf_skip ? (idx == hi_idx) : (idx == LW'(NUM_LANES - 1));
  end

  // Ready while the last slot is going out lets the next set chain in gap-free.
  assign in_if.in_ready = !full || is_last;
  assign accept         = in_if.in_load && in_if.in_ready;
  // An all-invalid set in compaction mode is accepted but holds nothing.
  assign load_set       = accept && (!in_if.skip_invalid || (|in_if.in_valid));
  assign busy           = full;

  // Word storage needs no reset: it is only read while full is set.
  always_ff @(posedge clk) begin
    if (load_set) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        buf_word[i] <= in_if.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_out  <= IDLE_SYM;
      valid_out <= 1'b0;
      lane_out  <= '0;
      full      <= 1'b0;
      idx       <= '0;
      buf_valid <= '0;
      buf_skip  <= 1'b0;
    end else begin
      if (full) begin
        valid_out <= buf_valid[idx];
        data_out  <= buf_valid[idx] ? buf_word[idx] : IDLE_SYM;
        lane_out  <= idx;
        if (is_last) begin
          full <= 1'b0;
        end else begin
          idx <= nxt_idx;
        end
      end else begin
        data_out  <= IDLE_SYM;
        valid_out <= 1'b0;
        lane_out  <= '0;
      end
      // Placed after the emit logic so a same-edge load overrides full/idx.
      if (load_set) begin
        full      <= 1'b1;
        buf_valid <= in_if.in_valid;
        buf_skip  <= in_if.skip_invalid;
        idx       <= in_if.skip_invalid ? lo_in_idx : '0;
      end
    end
  end

endmodule
